// File: rtl/imsic_csr_port_arbiter_if.sv
// Bundle of requester-side and IMSIC-side CSR port signals shared by the arbiter.
// The master modport is the arbiter view. The slave modport is the hart/IMSIC environment view.
interface imsic_csr_port_arbiter_if #(
  parameter int NR_REQ                = 4,
  parameter int NR_IMSICS             = 4,
  parameter int NR_VS_FILES_PER_IMSIC = 1,
  parameter int VS_INTP_FILE_LEN      = $clog2(NR_VS_FILES_PER_IMSIC),
  parameter int IDX_W                 = $clog2(NR_IMSICS) + 1
);
  logic [NR_REQ-1:0]                       i_req_valid;
  logic [NR_REQ-1:0]                       o_req_ready;
  logic [NR_REQ-1:0][IDX_W-1:0]            i_req_imsic;
  logic [NR_REQ-1:0][1:0]                  i_req_priv;
  logic [NR_REQ-1:0][VS_INTP_FILE_LEN:0]   i_req_vgein;
  logic [NR_REQ-1:0][31:0]                 i_req_addr;
  logic [NR_REQ-1:0][31:0]                 i_req_data;
  logic [NR_REQ-1:0]                       i_req_we;
  logic [NR_REQ-1:0]                       i_req_claim;
  logic [NR_REQ-1:0]                       o_rsp_valid;
  logic [31:0]                             o_rsp_rdata;
  logic                                    o_rsp_err;
  logic [NR_IMSICS-1:0]                    o_select_imsic;
  logic [1:0]                              o_priv_lvl;
  logic [VS_INTP_FILE_LEN:0]               o_vgein;
  logic [31:0]                             o_imsic_addr;
  logic [31:0]                             o_imsic_data;
  logic                                    o_imsic_we;
  logic                                    o_imsic_claim;
  logic [NR_IMSICS-1:0][31:0]              i_imsic_rdata;
  logic [NR_IMSICS-1:0]                    i_imsic_exception;

  modport master (
    input  i_req_valid, i_req_imsic, i_req_priv, i_req_vgein, i_req_addr, i_req_data,
           i_req_we, i_req_claim, i_imsic_rdata, i_imsic_exception,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_select_imsic, o_priv_lvl,
           o_vgein, o_imsic_addr, o_imsic_data, o_imsic_we, o_imsic_claim
  );

  modport slave (
    output i_req_valid, i_req_imsic, i_req_priv, i_req_vgein, i_req_addr, i_req_data,
           i_req_we, i_req_claim, i_imsic_rdata, i_imsic_exception,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_select_imsic, o_priv_lvl,
           o_vgein, o_imsic_addr, o_imsic_data, o_imsic_we, o_imsic_claim
  );
endinterface

// File: rtl/imsic_csr_port_arbiter.sv
// Arbitrates NR_REQ CSR requesters onto one IMSIC CSR port. Each request is one 4-cycle transaction.
// Define IMSIC_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module imsic_csr_port_arbiter #(
  parameter int NR_REQ                = 4,
  parameter int NR_IMSICS             = 4,
  parameter int NR_VS_FILES_PER_IMSIC = 1,
  parameter int VS_INTP_FILE_LEN      = $clog2(NR_VS_FILES_PER_IMSIC),
  parameter int IDX_W                 = $clog2(NR_IMSICS) + 1
) (
  input  logic                            i_clk,
  input  logic                            ni_rst,
  imsic_csr_port_arbiter_if.master        bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  function automatic logic [NR_REQ-1:0] lowest_one(input logic [NR_REQ-1:0] v);
    lowest_one = '0;
    for (int i = NR_REQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        lowest_one    = '0;
        lowest_one[i] = 1'b1;
      end
    end
  endfunction

  logic [1:0]                 state;
  logic [NR_REQ-1:0]          cand;
  logic [NR_REQ-1:0]          grant;

  logic [IDX_W-1:0]           win_imsic;
  logic [1:0]                 win_priv;
  logic [VS_INTP_FILE_LEN:0]  win_vgein;
  logic [31:0]                win_addr;
  logic [31:0]                win_data;
  logic                       win_we;
  logic                       win_claim;
  logic                       win_bad;
  logic [NR_IMSICS-1:0]       win_sel;

  logic [NR_REQ-1:0]          owner_p0;
  logic [NR_IMSICS-1:0]       sel_p0;
  logic [1:0]                 priv_p0;
  logic [VS_INTP_FILE_LEN:0]  vgein_p0;
  logic [31:0]                addr_p0;
  logic [31:0]                data_p0;
  logic                       we_p0;
  logic                       claim_p0;
  logic                       bad_p0;

  logic [31:0]                cap_rdata;
  logic                       cap_exc;
  logic [31:0]                rsp_rdata_p1;
  logic                       rsp_err_p1;
  logic                       issue;

`ifdef IMSIC_ARB_ROUND_ROBIN_EN
  localparam int REQ_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  logic [REQ_W-1:0]  rr_ptr;
  logic [REQ_W-1:0]  win_idx;
  logic [NR_REQ-1:0] upper;

  // Requesters at or above the pointer get first pick; wrap to the full set if none.
  always_comb begin
    upper = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      upper[i] = bus.i_req_valid[i] && (REQ_W'(i) >= rr_ptr);
    end
    cand = (|upper) ? upper : bus.i_req_valid;
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (grant[i]) win_idx = REQ_W'(i);
    end
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      rr_ptr <= '0;
    end else if (state == IDLE && |grant) begin
      rr_ptr <= (win_idx == REQ_W'(NR_REQ - 1)) ? '0 : win_idx + REQ_W'(1);
    end
  end
`else
  assign cand = bus.i_req_valid;
`endif

  assign grant = (state == IDLE && ni_rst) ? lowest_one(cand) : '0;

  always_comb begin
    win_imsic = '0;
    win_priv  = '0;
    win_vgein = '0;
    win_addr  = '0;
    win_data  = '0;
    win_we    = 1'b0;
    win_claim = 1'b0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (grant[i]) begin
        win_imsic = bus.i_req_imsic[i];
        win_priv  = bus.i_req_priv[i];
        win_vgein = bus.i_req_vgein[i];
        win_addr  = bus.i_req_addr[i];
        win_data  = bus.i_req_data[i];
        win_we    = bus.i_req_we[i];
        win_claim = bus.i_req_claim[i];
      end
    end
    win_bad = (win_imsic >= IDX_W'(NR_IMSICS)) || (win_we && win_claim);
    win_sel = '0;
    for (int j = 0; j < NR_IMSICS; j++) begin
      if (!win_bad && win_imsic == IDX_W'(j)) win_sel[j] = 1'b1;
    end
  end

  // A bad request has an all-zero select, so the capture mux yields rdata 0 and no exception.
  always_comb begin
    cap_rdata = '0;
    cap_exc   = 1'b0;
    for (int j = 0; j < NR_IMSICS; j++) begin
      if (sel_p0[j]) begin
        cap_rdata = bus.i_imsic_rdata[j];
        cap_exc   = bus.i_imsic_exception[j];
      end
    end
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      state        <= IDLE;
      owner_p0     <= '0;
      sel_p0       <= '0;
      priv_p0      <= '0;
      vgein_p0     <= '0;
      addr_p0      <= '0;
      data_p0      <= '0;
      we_p0        <= 1'b0;
      claim_p0     <= 1'b0;
      bad_p0       <= 1'b0;
      rsp_rdata_p1 <= '0;
      rsp_err_p1   <= 1'b0;
    end else begin
      case (state)
        // p0: latch the winner's request at accept time
        IDLE: begin
          if (|grant) begin
            state    <= ISSUE;
            owner_p0 <= grant;
            sel_p0   <= win_sel;
            priv_p0  <= win_priv;
            vgein_p0 <= win_vgein;
            addr_p0  <= win_addr;
            data_p0  <= win_data;
            we_p0    <= win_we;
            claim_p0 <= win_claim;
            bad_p0   <= win_bad;
          end
        end
        ISSUE: state <= CAPTURE;
        // p1: capture the selected IMSIC's read data one cycle after issue
        CAPTURE: begin
          state        <= RESP;
          rsp_rdata_p1 <= cap_rdata;
          rsp_err_p1   <= bad_p0 | cap_exc;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign issue = (state == ISSUE);

  assign bus.o_req_ready    = grant;
  assign bus.o_select_imsic = issue ? sel_p0   : '0;
  assign bus.o_priv_lvl     = issue ? priv_p0  : '0;
  assign bus.o_vgein        = issue ? vgein_p0 : '0;
  assign bus.o_imsic_addr   = issue ? addr_p0  : '0;
  assign bus.o_imsic_data   = issue ? data_p0  : '0;
  assign bus.o_imsic_we     = issue && !bad_p0 && we_p0;
  assign bus.o_imsic_claim  = issue && !bad_p0 && claim_p0;
  assign bus.o_rsp_valid    = (state == RESP) ? owner_p0 : '0;
  assign bus.o_rsp_rdata    = rsp_rdata_p1;
  assign bus.o_rsp_err      = rsp_err_p1;

endmodule

// File: tb/tb_imsic_csr_port_arbiter.sv
// Directed bench for imsic_csr_port_arbiter with a response scoreboard and a simple IMSIC model.
module tb_imsic_csr_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [3:0]  owner;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic [31:0] imsic_val [4];
  logic [3:0]  exc_flag;
  logic [3:0]  pend;

  imsic_csr_port_arbiter_if #(.NR_REQ(4), .NR_IMSICS(4), .NR_VS_FILES_PER_IMSIC(1)) bus ();

  imsic_csr_port_arbiter #(.NR_REQ(4), .NR_IMSICS(4), .NR_VS_FILES_PER_IMSIC(1)) dut (
    .i_clk  (clk),
    .ni_rst (rst_n),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // IMSIC model: read data and exception are valid only in the cycle after select.
  initial begin
    pend = '0;
    bus.i_imsic_rdata     = '0;
    bus.i_imsic_exception = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        bus.i_imsic_rdata[k]     = pend[k] ? imsic_val[k] : (32'hDEAD_0000 | 32'(k));
        bus.i_imsic_exception[k] = pend[k] & exc_flag[k];
      end
      pend = bus.o_select_imsic;
    end
  end

  // Response monitor: pops the scoreboard on every response pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_rsp_valid !== 4'b0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(bus.o_rsp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_owner", 64'(bus.o_rsp_valid), 64'(e.owner));
          check("rsp_rdata", 64'(bus.o_rsp_rdata), 64'(e.rdata));
          check("rsp_err",   64'(bus.o_rsp_err),   64'(e.err));
          check("rsp_cycle", 64'(cyc),             64'(e.due));
        end
      end
    end
  end

  task automatic wait_ready(input logic [3:0] mask, output logic ok);
    int w = 0;
    #1;
    while (((bus.o_req_ready & mask) === 4'b0) && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    ok = ((bus.o_req_ready & mask) !== 4'b0);
  endtask

  task automatic drain(input string tag);
    int w = 0;
    while (sb.size() != 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic do_req(input logic [1:0] r, input int imsic, input logic [31:0] addr,
                        input logic [31:0] data, input logic we, input logic claim,
                        input string tag);
    logic       ok;
    logic       bad;
    logic [3:0] exp_sel;
    exp_t       e;
    bad     = (imsic >= 4) || (we && claim);
    exp_sel = bad ? 4'b0 : (4'b1 << imsic[1:0]);
    @(negedge clk);
    bus.i_req_valid[r] = 1'b1;
    bus.i_req_imsic[r] = 3'(imsic);
    bus.i_req_priv[r]  = 2'd3;
    bus.i_req_addr[r]  = addr;
    bus.i_req_data[r]  = data;
    bus.i_req_we[r]    = we;
    bus.i_req_claim[r] = claim;
    wait_ready(4'b1 << r, ok);
    check({tag, "_ready"}, 64'(bus.o_req_ready), 64'(4'b1 << r));
    if (ok) begin
      e.owner = 4'b1 << r;
      e.rdata = bad ? 32'h0 : imsic_val[imsic[1:0]];
      e.err   = bad ? 1'b1 : exc_flag[imsic[1:0]];
      e.due   = cyc + 3;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.i_req_valid[r] = 1'b0;
    @(negedge clk);
    check({tag, "_sel"},   64'(bus.o_select_imsic), 64'(exp_sel));
    check({tag, "_we"},    64'(bus.o_imsic_we),     64'(!bad && we));
    check({tag, "_claim"}, 64'(bus.o_imsic_claim),  64'(!bad && claim));
    check({tag, "_addr"},  64'(bus.o_imsic_addr),   64'(addr));
    check({tag, "_data"},  64'(bus.o_imsic_data),   64'(data));
    check({tag, "_priv"},  64'(bus.o_priv_lvl),     64'd3);
    @(negedge clk);
    check({tag, "_sel_off"},   64'(bus.o_select_imsic), 64'd0);
    check({tag, "_strobe_off"}, 64'({bus.o_imsic_we, bus.o_imsic_claim}), 64'd0);
    drain({tag, "_drain"});
  endtask

  initial begin
    logic       ok;
    int         prev;
    logic [1:0] exp_w;
    imsic_val[0] = 32'h0000_1010;
    imsic_val[1] = 32'h0000_2121;
    imsic_val[2] = 32'h0000_00A5;
    imsic_val[3] = 32'h0000_3333;
    exc_flag = 4'b0;
    bus.i_req_valid = '0;
    bus.i_req_imsic = '0;
    bus.i_req_priv  = '0;
    bus.i_req_vgein = '0;
    bus.i_req_addr  = '0;
    bus.i_req_data  = '0;
    bus.i_req_we    = '0;
    bus.i_req_claim = '0;

    repeat (3) @(negedge clk);
    check("rst_ready",     64'(bus.o_req_ready),    64'd0);
    check("rst_rsp_valid", 64'(bus.o_rsp_valid),    64'd0);
    check("rst_select",    64'(bus.o_select_imsic), 64'd0);
    check("rst_rsp_data",  64'({bus.o_rsp_rdata, bus.o_rsp_err}), 64'd0);
    check("rst_strobes",   64'({bus.o_imsic_we, bus.o_imsic_claim}), 64'd0);
    rst_n = 1'b1;

    do_req(2'd0, 2, 32'h70, 32'h0, 1'b0, 1'b0, "read0");
    do_req(2'd1, 5, 32'h74, 32'h0, 1'b0, 1'b0, "badidx");
    do_req(2'd3, 1, 32'h78, 32'h55, 1'b1, 1'b1, "weclaim");
    do_req(2'd2, 0, 32'h7C, 32'h0, 1'b0, 1'b1, "claim");

    // Async reset during ISSUE of a write: outputs drop at once and the request is lost.
    @(negedge clk);
    bus.i_req_valid[2] = 1'b1;
    bus.i_req_imsic[2] = 3'd1;
    bus.i_req_addr[2]  = 32'h44;
    bus.i_req_data[2]  = 32'h1234;
    bus.i_req_we[2]    = 1'b1;
    bus.i_req_claim[2] = 1'b0;
    wait_ready(4'b0100, ok);
    check("midrst_ready", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    bus.i_req_valid[2] = 1'b0;
    bus.i_req_we[2]    = 1'b0;
    @(negedge clk);
    check("midrst_we_before", 64'(bus.o_imsic_we), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_we",     64'(bus.o_imsic_we),     64'd0);
    check("midrst_select", 64'(bus.o_select_imsic), 64'd0);
    check("midrst_addr",   64'(bus.o_imsic_addr),   64'd0);
    check("midrst_rsp",    64'({bus.o_rsp_valid, bus.o_rsp_rdata, bus.o_rsp_err}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", 64'(bus.o_rsp_valid), 64'd0);
    end

    // All four requesters held: arbitration order and 4-cycle spacing.
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      bus.i_req_imsic[r] = 3'(r);
      bus.i_req_we[r]    = 1'b0;
      bus.i_req_claim[r] = 1'b0;
    end
    bus.i_req_valid = 4'b1111;
    prev = 0;
`ifdef IMSIC_ARB_ROUND_ROBIN_EN
    for (int g = 0; g < 5; g++) begin
      exp_w = 2'(g % 4);
`else
    for (int g = 0; g < 3; g++) begin
      exp_w = 2'd0;
`endif
      if (g > 0) @(negedge clk);
      wait_ready(4'b1111, ok);
      check("arb_grant", 64'(bus.o_req_ready), 64'(4'b1 << exp_w));
      if (g > 0) check("arb_spacing", 64'(cyc - prev), 64'd4);
      prev = cyc;
      if (ok) sb.push_back('{owner: bus.o_req_ready, rdata: imsic_val[exp_w], err: 1'b0, due: cyc + 3});
      @(posedge clk);
      #1;
    end
    bus.i_req_valid = 4'b0;
    drain("arb_drain");

    // Exception raised by IMSIC3 on a write.
    exc_flag[3] = 1'b1;
    do_req(2'd1, 3, 32'h80, 32'hCAFE, 1'b1, 1'b0, "exc3");
    exc_flag[3] = 1'b0;

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
